led_mode_indicator: RTL and testbench



---
 rtl/led_mode_pkg.sv | 39 +++
 rtl/led_mode_indicator_blink_divider.sv | 41 ++++
 rtl/led_mode_indicator.sv | 133 +++++++++++++
 tb/tb_led_mode_indicator.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_mode_pkg.sv
// led_mode_pkg
// Shared types and helpers for the LED mode indicator.
//   settle_state_t : state of the selector settle FSM
//   pattern()      : LED drive pattern for a given mode and LED count
//   clog2_min1()   : counter width helper that never returns zero
package led_mode_pkg;

  // Settle FSM states: STABLE holds the committed mode, SETTLING is
  // watching a candidate mode that has not yet been held long enough.
  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } settle_state_t;

  // Widest LED bank the pattern helper can describe.
  localparam int MAX_LEDS = 32;

  // Width of a counter that must hold values 0..n-1, at least one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Modes below the LED count light a single LED; higher modes light a
  // growing bar from bit 0 that saturates at all-ones. The vector is
  // built by shifting so no variable bit index is needed.
  function automatic logic [MAX_LEDS-1:0] pattern(input int m, input int n);
    logic [MAX_LEDS-1:0] p;
    int                  bar;
    p   = '0;
    bar = m - n + 2;
    if (bar > n) bar = n;
    for (int i = MAX_LEDS - 1; i >= 0; i--) begin
      if (m < n) p = {p[MAX_LEDS-2:0], (i == m)};
      else       p = {p[MAX_LEDS-2:0], (i < bar)};
    end
    return p;
  endfunction

endpackage

// File: rtl/led_mode_indicator_blink_divider.sv
// blink_divider
// Free-running blink timebase. Counts 0..BLINK_DIV-1 and toggles phase on
// each wrap, so phase has a half-period of BLINK_DIV cycles.
//   clk     : system clock, rising edge
//   rst_n   : synchronous active-low reset (counter 0, phase 1)
//   restart : restart the half-period with phase 1 (used on mode commit)
//   phase   : 1 = LEDs lit half, 0 = LEDs dark half
module blink_divider
  import led_mode_pkg::*;
#(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic phase
);

  localparam int              DW   = clog2_min1(BLINK_DIV);
  localparam logic [DW-1:0]   LAST = DW'(BLINK_DIV - 1);

  logic [DW-1:0] count;

  // Restart wins over a wrap in the same cycle so a freshly committed
  // pattern always begins with a full lit half-period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      phase <= 1'b1;
    end else if (restart) begin
      count <= '0;
      phase <= 1'b1;
    end else if (count == LAST) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + DW'(1);
    end
  end

endmodule

// File: rtl/led_mode_indicator.sv
// led_mode_indicator
// Debounces a mode selector and drives registered status LEDs plus a
// per-mode numeric value.
//   clk          : system clock, rising edge
//   rst_n        : synchronous active-low reset
//   mode         : requested mode, sampled every clock
//   blink_en     : 1 = LEDs blink with the divider phase, 0 = steady
//   out          : ((active_mode+1)*STEP) truncated to OUT_W bits
//   led          : registered LED drive for the committed mode
//   active_mode  : committed mode
//   busy         : high while a candidate mode is settling
//   mode_changed : one-cycle pulse on the cycle after a commit edge
module led_mode_indicator
  import led_mode_pkg::*;
#(
  parameter int MODE_W    = 2,
  parameter int NUM_LEDS  = 3,
  parameter int OUT_W     = 11,
  parameter int STEP      = 5,
  parameter int SETTLE    = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MODE_W-1:0]   mode,
  input  logic                blink_en,
  output logic [OUT_W-1:0]    out,
  output logic [NUM_LEDS-1:0] led,
  output logic [MODE_W-1:0]   active_mode,
  output logic                busy,
  output logic                mode_changed
);

  // The settle counter holds how many consecutive samples of the
  // candidate have been seen; the commit happens on the sample that
  // would take it to SETTLE, i.e. while it still reads SETTLE-1.
  localparam int               SCW         = clog2_min1(SETTLE + 1);
  localparam logic [SCW-1:0]   SETTLE_LAST = SCW'(SETTLE - 1);

  settle_state_t        state;
  logic [MODE_W-1:0]    cand;
  logic [SCW-1:0]       cnt;
  logic                 phase;
  logic                 commit;
  logic [MODE_W-1:0]    commit_mode;
  logic [NUM_LEDS-1:0]  pat_active;
  logic [NUM_LEDS-1:0]  pat_commit;

  // Numeric value for a mode; the multiply wraps modulo 2^32 which
  // agrees with the required modulo 2^OUT_W after truncation.
  function automatic logic [OUT_W-1:0] mode_value(input logic [MODE_W-1:0] m);
    logic [31:0] v;
    v = (32'(m) + 32'd1) * STEP;
    return OUT_W'(v);
  endfunction

  // Commit decision. With SETTLE=1 a differing mode commits straight
  // from STABLE, so SETTLING is never entered.
  always_comb begin
    commit      = 1'b0;
    commit_mode = cand;
    if (state == STABLE) begin
      if (mode != active_mode && SETTLE == 1) begin
        commit      = 1'b1;
        commit_mode = mode;
      end
    end else begin
      if (mode != active_mode && mode == cand && cnt == SETTLE_LAST) begin
        commit = 1'b1;
      end
    end
  end

  assign pat_active = NUM_LEDS'(pattern(int'(active_mode), NUM_LEDS));
  assign pat_commit = NUM_LEDS'(pattern(int'(commit_mode), NUM_LEDS));
  assign busy       = (state == SETTLING);

  // Settle FSM and output registers. On a commit the LEDs show the new
  // pattern at once, matching the divider restarting in its lit phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= STABLE;
      cand         <= '0;
      cnt          <= '0;
      active_mode  <= '0;
      out          <= mode_value('0);
      led          <= NUM_LEDS'(pattern(0, NUM_LEDS));
      mode_changed <= 1'b0;
    end else begin
      mode_changed <= commit;
      if (commit) begin
        active_mode <= commit_mode;
        out         <= mode_value(commit_mode);
        led         <= pat_commit;
        state       <= STABLE;
        cnt         <= '0;
      end else begin
        led <= blink_en ? (pat_active & {NUM_LEDS{phase}}) : pat_active;
        unique case (state)
          STABLE: begin
            if (mode != active_mode) begin
              state <= SETTLING;
              cand  <= mode;
              cnt   <= SCW'(1);
            end
          end
          SETTLING: begin
            if (mode == active_mode) begin
              state <= STABLE;
              cnt   <= '0;
            end else if (mode != cand) begin
              cand <= mode;
              cnt  <= SCW'(1);
            end else begin
              cnt <= cnt + SCW'(1);
            end
          end
          default: state <= STABLE;
        endcase
      end
    end
  end

  blink_divider #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(commit),
    .phase  (phase)
  );

endmodule

// File: tb/tb_led_mode_indicator.sv
// tb_led_mode_indicator
// Drives two indicator instances from one stimulus stream:
//   dut_a : 2-bit mode, STEP=5, SETTLE=4, BLINK_DIV=4
//   dut_b : 3-bit mode, STEP=300 (output truncates), SETTLE=1, BLINK_DIV=2
// A cycle model predicts every output; predictions are queued when the
// stimulus is driven and compared once the clock edge has happened.
module tb_led_mode_indicator;

  typedef struct {
    int active;
    int cand;
    int cnt;
    int dcnt;
    bit settling;
    bit phase;
    int out;
    int led;
    bit busy;
    bit chg;
  } mstate_t;

  typedef struct {
    mstate_t a;
    mstate_t b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        blink_en = 1'b0;
  logic [1:0]  mode_a = '0;
  logic [2:0]  mode_b = '0;
  logic [10:0] out_a, out_b;
  logic [2:0]  led_a, led_b;
  logic [1:0]  active_a;
  logic [2:0]  active_b;
  logic        busy_a, busy_b, chg_a, chg_b;

  int      total = 0;
  int      bad = 0;
  exp_t    exp_q[$];
  mstate_t ma_st, mb_st;

  always #5 clk = ~clk;

  led_mode_indicator #(
    .MODE_W(2), .NUM_LEDS(3), .OUT_W(11), .STEP(5), .SETTLE(4), .BLINK_DIV(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode_a), .blink_en(blink_en),
    .out(out_a), .led(led_a), .active_mode(active_a), .busy(busy_a),
    .mode_changed(chg_a)
  );

  led_mode_indicator #(
    .MODE_W(3), .NUM_LEDS(3), .OUT_W(11), .STEP(300), .SETTLE(1), .BLINK_DIV(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode_b), .blink_en(blink_en),
    .out(out_b), .led(led_b), .active_mode(active_b), .busy(busy_b),
    .mode_changed(chg_b)
  );

  // Single point of comparison: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference LED pattern: one-hot below the LED count, then a bar.
  function automatic int ref_pattern(input int m, input int n);
    int k;
    if (m < n) return 1 << m;
    k = m - n + 2;
    if (k > n) k = n;
    return (1 << k) - 1;
  endfunction

  // One clock edge of the reference behaviour.
  function automatic mstate_t model_step(input mstate_t s, input int m,
      input bit blink, input bit rstn, input int step, input int settle,
      input int div, input int outw, input int nleds);
    mstate_t n;
    bit      commit;
    n      = s;
    commit = 1'b0;
    if (!rstn) begin
      n.active = 0; n.cand = 0; n.cnt = 0; n.dcnt = 0;
      n.settling = 0; n.phase = 1;
      n.out = step % (1 << outw);
      n.led = ref_pattern(0, nleds);
      n.busy = 0; n.chg = 0;
      return n;
    end
    if (!s.settling) begin
      if (m != s.active) begin
        n.cand = m; n.cnt = 1;
        if (settle == 1) commit = 1; else n.settling = 1;
      end
    end else if (m == s.active) begin
      n.settling = 0;
    end else if (m != s.cand) begin
      n.cand = m; n.cnt = 1;
    end else begin
      n.cnt = s.cnt + 1;
      if (n.cnt == settle) commit = 1;
    end
    if (commit) begin
      n.active = n.cand; n.settling = 0;
      n.led = ref_pattern(n.cand, nleds);
      n.dcnt = 0; n.phase = 1;
    end else begin
      n.led = (blink && !s.phase) ? 0 : ref_pattern(s.active, nleds);
      if (s.dcnt == div - 1) begin
        n.dcnt = 0; n.phase = !s.phase;
      end else begin
        n.dcnt = s.dcnt + 1;
      end
    end
    n.out  = ((n.active + 1) * step) % (1 << outw);
    n.busy = n.settling;
    n.chg  = commit;
    return n;
  endfunction

  // Drive one cycle of inputs, queue the prediction, step past the edge.
  task automatic applyStimulus(input bit rstn, input int ma, input int mb,
                               input bit blink);
    exp_t e;
    rst_n    = rstn;
    mode_a   = 2'(ma);
    mode_b   = 3'(mb);
    blink_en = blink;
    ma_st = model_step(ma_st, ma, blink, rstn, 5, 4, 4, 11, 3);
    mb_st = model_step(mb_st, mb, blink, rstn, 300, 1, 2, 11, 3);
    e.a = ma_st;
    e.b = mb_st;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic cycles(input int num, input bit rstn, input int ma,
                        input bit blink);
    for (int i = 0; i < num; i++)
      applyStimulus(rstn, ma, $urandom_range(0, 7), blink);
  endtask

  // Scoreboard consumer: compares each queued prediction after its edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("a.out",    32'(out_a),    e.a.out);
        checkOutput("a.led",    32'(led_a),    e.a.led);
        checkOutput("a.active", 32'(active_a), e.a.active);
        checkOutput("a.busy",   32'(busy_a),   32'(e.a.busy));
        checkOutput("a.chg",    32'(chg_a),    32'(e.a.chg));
        checkOutput("b.out",    32'(out_b),    e.b.out);
        checkOutput("b.led",    32'(led_b),    e.b.led);
        checkOutput("b.active", 32'(active_b), e.b.active);
        checkOutput("b.busy",   32'(busy_b),   32'(e.b.busy));
        checkOutput("b.chg",    32'(chg_b),    32'(e.b.chg));
      end
    end
  end

  initial begin
    ma_st = '{default: 0};
    mb_st = '{default: 0};
    $display("[TB] start");

    // Reset held with a new mode requested, then release and settle.
    cycles(1, 1'b0, 0, 1'b0);
    cycles(3, 1'b0, 2, 1'b0);
    checkOutput("t1_rst_out", 32'(out_a), 5);
    checkOutput("t1_rst_led", 32'(led_a), 1);
    checkOutput("t1_rst_busy", 32'(busy_a), 0);
    cycles(3, 1'b1, 2, 1'b0);
    checkOutput("t1_pre_out", 32'(out_a), 5);
    cycles(1, 1'b1, 2, 1'b0);
    checkOutput("t1_out", 32'(out_a), 15);
    checkOutput("t1_led", 32'(led_a), 4);
    checkOutput("t1_chg", 32'(chg_a), 1);
    cycles(1, 1'b1, 2, 1'b0);
    checkOutput("t1_chg_off", 32'(chg_a), 0);

    // Bounce back to the committed mode: no commit.
    cycles(1, 1'b0, 0, 1'b0);
    cycles(3, 1'b1, 3, 1'b0);
    checkOutput("t2_busy", 32'(busy_a), 1);
    cycles(1, 1'b1, 0, 1'b0);
    checkOutput("t2_out", 32'(out_a), 5);
    checkOutput("t2_busy_off", 32'(busy_a), 0);
    cycles(4, 1'b1, 3, 1'b0);
    checkOutput("t2_out3", 32'(out_a), 20);
    checkOutput("t2_led3", 32'(led_a), 3);

    // Candidate change restarts the settle count.
    cycles(1, 1'b0, 0, 1'b0);
    cycles(2, 1'b1, 1, 1'b0);
    cycles(3, 1'b1, 2, 1'b0);
    checkOutput("t3_pre_out", 32'(out_a), 5);
    cycles(1, 1'b1, 2, 1'b0);
    checkOutput("t3_out", 32'(out_a), 15);

    // Blinking pattern for mode 1 and switching blink off while dark.
    cycles(1, 1'b0, 0, 1'b1);
    cycles(1, 1'b1, 0, 1'b1);
    cycles(4, 1'b1, 1, 1'b1);
    checkOutput("t4_commit_led", 32'(led_a), 2);
    cycles(6, 1'b1, 1, 1'b1);
    checkOutput("t4_dark_led", 32'(led_a), 0);
    cycles(1, 1'b1, 1, 1'b0);
    checkOutput("t4_steady_led", 32'(led_a), 2);
    cycles(5, 1'b1, 1, 1'b1);

    // Commit on the same edge the divider would wrap.
    cycles(1, 1'b0, 0, 1'b1);
    cycles(4, 1'b1, 2, 1'b1);
    checkOutput("t5_commit_led", 32'(led_a), 4);
    cycles(3, 1'b1, 2, 1'b1);
    checkOutput("t5_still_lit", 32'(led_a), 4);
    cycles(6, 1'b1, 2, 1'b1);

    // Wide-mode instance: truncated output and saturated bar.
    applyStimulus(1'b1, 2, 7, 1'b0);
    checkOutput("t6_out7", 32'(out_b), 352);
    checkOutput("t6_led7", 32'(led_b), 7);
    applyStimulus(1'b1, 2, 3, 1'b0);
    checkOutput("t6_out3", 32'(out_b), 1200);
    checkOutput("t6_led3", 32'(led_b), 3);
    applyStimulus(1'b1, 2, 5, 1'b0);
    checkOutput("t6_led5", 32'(led_b), 7);

    // Reset in the middle of settling discards the candidate.
    cycles(2, 1'b1, 3, 1'b0);
    checkOutput("t6_settling", 32'(busy_a), 1);
    cycles(1, 1'b0, 3, 1'b0);
    checkOutput("t6_rst_busy", 32'(busy_a), 0);
    checkOutput("t6_rst_active", 32'(active_a), 0);
    checkOutput("t6_rst_out", 32'(out_a), 5);
    checkOutput("t6_rst_led", 32'(led_a), 1);

    // Randomised tail exercising both instances.
    for (int i = 0; i < 200; i++)
      applyStimulus(($urandom_range(0, 30) != 0), $urandom_range(0, 3),
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)));

    checkOutput("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
